// File: rtl/heap_pkg.sv
// heap_pkg: shared action codes, error codes and FSM state type for heap_responder.
package heap_pkg;

    typedef enum logic [7:0] {
        NOP    = 8'd0,
        ALLOC  = 8'd1,
        FREE   = 8'd2,
        READ   = 8'd3,
        WRITE  = 8'd4,
        LENGTH = 8'd5,
        PUSH   = 8'd6,
        POP    = 8'd7,
        RESIZE = 8'd8
    } heapAction_e;

    localparam logic [31:0] ERR_NONE    = 32'd0;
    localparam logic [31:0] ERR_NO_FREE = 32'd1;
    localparam logic [31:0] ERR_UNALLOC = 32'd2;
    localparam logic [31:0] ERR_BOUNDS  = 32'd3;
    localparam logic [31:0] ERR_FULL    = 32'd4;
    localparam logic [31:0] ERR_EMPTY   = 32'd5;
    localparam logic [31:0] ERR_RESIZE  = 32'd6;
    localparam logic [31:0] ERR_UNKNOWN = 32'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } heapState_e;

endpackage

// File: rtl/heap_responder_if.sv
// heap_responder_if: toggle-handshake request/response bundle between initiator and heap_responder.
interface heap_responder_if #(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned ARRAYS = 4,
    parameter int unsigned SIZE   = 4
) ();
    logic                        heap_clock;
    logic [7:0]                  heap_action;
    logic [$clog2(ARRAYS)-1:0]   heap_array;
    logic [$clog2(SIZE)-1:0]     heap_index;
    logic [WIDTH-1:0]            heap_in;
    logic [WIDTH-1:0]            heap_out;
    logic [31:0]                 heap_error;
    logic                        heap_ack;
    logic                        heap_busy;

    modport master (
        output heap_clock, heap_action, heap_array, heap_index, heap_in,
        input  heap_out, heap_error, heap_ack, heap_busy
    );

    modport slave (
        input  heap_clock, heap_action, heap_array, heap_index, heap_in,
        output heap_out, heap_error, heap_ack, heap_busy
    );
endinterface

// File: rtl/heap_array_ram.sv
// heap_array_ram: single-port element store, synchronous write and combinational read.
module heap_array_ram #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     writeEnable,
    input  logic [$clog2(DEPTH)-1:0] address,
    input  logic [WIDTH-1:0]         writeData,
    output logic [WIDTH-1:0]         readData
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (writeEnable) mem[address] <= writeData;
    end

    assign readData = mem[address];
endmodule

// File: rtl/heap_responder.sv
// heap_responder: toggle-handshake responder managing ARRAYS arrays of up to SIZE WIDTH-bit words.
// Define HEAP_BOUNDS_CHECK_EN to raise error 3 on out-of-range READ/WRITE instead of wrapping indices.
module heap_responder
    import heap_pkg::*;
#(
    parameter int unsigned WIDTH  = 12,
    parameter int unsigned ARRAYS = 4,
    parameter int unsigned SIZE   = 4
) (
    input logic             clock,
    input logic             reset,
    heap_responder_if.slave heap
);
    localparam int unsigned AW = $clog2(ARRAYS);
    localparam int unsigned IW = $clog2(SIZE);
    localparam int unsigned LW = $clog2(SIZE + 1);

    heapState_e        state, stateNext;
    logic              servedPhase, pending;
    logic [7:0]        opReg;
    logic [AW-1:0]     arrReg;
    logic [IW-1:0]     idxReg;
    logic [WIDTH-1:0]  dinReg;
    logic [ARRAYS-1:0] allocFlags;
    logic [LW-1:0]     lengths [ARRAYS];
    logic [WIDTH-1:0]  outReg;
    logic [31:0]       errReg;
    logic              ackReg;

    logic [LW-1:0]     curLen, idxPlus1, lenNext;
    logic [31:0]       errNext;
    logic [WIDTH-1:0]  outNext, ramData;
    logic [IW-1:0]     ramIdx;
    logic [AW-1:0]     freeIdx;
    logic              ramWe, allocSet, allocClr, freeFound, readOob, writeOob;

    assign pending  = heap.heap_clock != servedPhase;
    assign curLen   = lengths[arrReg];
    assign idxPlus1 = LW'(idxReg) + LW'(1);

`ifdef HEAP_BOUNDS_CHECK_EN
    assign readOob  = LW'(idxReg) >= curLen;
    assign writeOob = idxPlus1 > LW'(SIZE);
`else
    assign readOob  = 1'b0;
    assign writeOob = 1'b0;
`endif

    // Descending scan so the final hit is the lowest-numbered free array.
    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int unsigned i = ARRAYS; i > 0; i--) begin
            if (!allocFlags[i-1]) begin
                freeFound = 1'b1;
                freeIdx   = AW'(i - 1);
            end
        end
    end

    always_comb begin
        errNext  = ERR_NONE;
        outNext  = '0;
        lenNext  = curLen;
        ramIdx   = idxReg;
        ramWe    = 1'b0;
        allocSet = 1'b0;
        allocClr = 1'b0;
        if (opReg > RESIZE) begin
            errNext = ERR_UNKNOWN;
        end else if (opReg == ALLOC) begin
            if (freeFound) begin
                outNext  = WIDTH'(freeIdx);
                allocSet = 1'b1;
            end else begin
                errNext = ERR_NO_FREE;
            end
        end else if (opReg != NOP && !allocFlags[arrReg]) begin
            errNext = ERR_UNALLOC;
        end else begin
            case (opReg)
                FREE:   allocClr = 1'b1;
                READ:   if (readOob) errNext = ERR_BOUNDS;
                        else outNext = ramData;
                WRITE:  if (writeOob) errNext = ERR_BOUNDS;
                        else begin
                            ramWe = 1'b1;
                            if (idxPlus1 > curLen) lenNext = idxPlus1;
                        end
                LENGTH: outNext = WIDTH'(curLen);
                PUSH:   if (curLen == LW'(SIZE)) errNext = ERR_FULL;
                        else begin
                            ramIdx  = curLen[IW-1:0];
                            ramWe   = 1'b1;
                            lenNext = curLen + LW'(1);
                        end
                POP:    if (curLen == '0) errNext = ERR_EMPTY;
                        else begin
                            ramIdx  = IW'(curLen - LW'(1));
                            outNext = ramData;
                            lenNext = curLen - LW'(1);
                        end
                RESIZE: if (dinReg > WIDTH'(SIZE)) errNext = ERR_RESIZE;
                        else lenNext = LW'(dinReg);
                default: ;
            endcase
        end
    end

    // Write is suppressed on the reset edge so an abandoned request leaves storage untouched.
    heap_array_ram #(.WIDTH(WIDTH), .DEPTH(ARRAYS * SIZE)) ram (
        .clock      (clock),
        .writeEnable(ramWe && (state == EXEC) && !reset),
        .address    ({arrReg, ramIdx}),
        .writeData  (dinReg),
        .readData   (ramData)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (pending) stateNext = EXEC;
            EXEC:    stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        heap.heap_busy  = (state == EXEC) || (state == DONE);
        heap.heap_out   = outReg;
        heap.heap_error = errReg;
        heap.heap_ack   = ackReg;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            servedPhase <= heap.heap_clock;
            allocFlags  <= '0;
            lengths     <= '{default: '0};
            outReg      <= '0;
            errReg      <= '0;
            ackReg      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pending) begin
                    servedPhase <= heap.heap_clock;
                    opReg       <= heap.heap_action;
                    arrReg      <= heap.heap_array;
                    idxReg      <= heap.heap_index;
                    dinReg      <= heap.heap_in;
                end
                EXEC: begin
                    outReg <= outNext;
                    errReg <= errNext;
                    if (allocSet) begin
                        allocFlags[freeIdx] <= 1'b1;
                        lengths[freeIdx]    <= '0;
                    end else if (errNext == ERR_NONE) begin
                        lengths[arrReg] <= lenNext;
                    end
                    if (allocClr) allocFlags[arrReg] <= 1'b0;
                end
                DONE: ackReg <= ~ackReg;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_heap_responder.sv
// tb_heap_responder: directed table, handshake corner sequences and randomized requests vs a reference model.
module tb_heap_responder;
    import heap_pkg::*;

`ifdef HEAP_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    heap_responder_if #(.WIDTH(12), .ARRAYS(4), .SIZE(4)) bus ();
    heap_responder #(.WIDTH(12), .ARRAYS(4), .SIZE(4)) dut (
        .clock(clock),
        .reset(reset),
        .heap (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int act;
        int arr;
        int idx;
        int din;
        int expOut;
        int expErr;
    } vec_t;
    vec_t vecs[$];

    bit mAlloc [4];
    int mLen   [4];
    int mMem   [16];
    bit mValid [16];

    function automatic void addVec(int act, int arr, int idx, int din, int eo, int ee);
        vec_t v;
        v = '{act, arr, idx, din, eo, ee};
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic void modelReset();
        for (int i = 0; i < 4; i++) begin
            mAlloc[i] = 1'b0;
            mLen[i]   = 0;
        end
    endfunction

    // Behavioural rules: returns expected out/error and whether out is a known value.
    task automatic modelExec(input int act, input int a, input int idx, input int din,
                             output int expOut, output int expErr, output bit known);
        int slot;
        expOut = 0;
        expErr = 0;
        known  = 1'b1;
        slot   = -1;
        if (act > 8) expErr = 7;
        else if (act == 1) begin
            for (int i = 3; i >= 0; i--) if (!mAlloc[i]) slot = i;
            if (slot < 0) expErr = 1;
            else begin
                mAlloc[slot] = 1'b1;
                mLen[slot]   = 0;
                expOut       = slot;
            end
        end else if (act == 0) begin
        end else if (!mAlloc[a]) expErr = 2;
        else begin
            case (act)
                2: mAlloc[a] = 1'b0;
                3: if (BOUNDS && idx >= mLen[a]) expErr = 3;
                   else begin
                       expOut = mMem[a*4 + idx];
                       known  = mValid[a*4 + idx];
                   end
                4: begin
                       mMem[a*4 + idx]   = din;
                       mValid[a*4 + idx] = 1'b1;
                       if (idx + 1 > mLen[a]) mLen[a] = idx + 1;
                   end
                5: expOut = mLen[a];
                6: if (mLen[a] == 4) expErr = 4;
                   else begin
                       mMem[a*4 + mLen[a]]   = din;
                       mValid[a*4 + mLen[a]] = 1'b1;
                       mLen[a]++;
                   end
                7: if (mLen[a] == 0) expErr = 5;
                   else begin
                       mLen[a]--;
                       expOut = mMem[a*4 + mLen[a]];
                       known  = mValid[a*4 + mLen[a]];
                   end
                default: if (din > 4) expErr = 6;
                         else mLen[a] = din;
            endcase
        end
    endtask

    task automatic drive(input int act, input int a, input int idx, input int din);
        bus.heap_action = 8'(act);
        bus.heap_array  = 2'(a);
        bus.heap_index  = 2'(idx);
        bus.heap_in     = 12'(din);
    endtask

    task automatic doReq(input int act, input int a, input int idx, input int din,
                         output int lat, output int o, output int e);
        logic prevAck;
        @(posedge clock); #1;
        drive(act, a, idx, din);
        bus.heap_clock = ~bus.heap_clock;
        prevAck = bus.heap_ack;
        lat = 99;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clock); #1;
            if (n == 1) check("busy_exec", bus.heap_busy, 1);
            if (bus.heap_ack != prevAck) begin
                lat = n;
                break;
            end
        end
        o = int'(bus.heap_out);
        e = int'(bus.heap_error);
    endtask

    task automatic runChecked(input string tag, input int act, input int a, input int idx, input int din);
        int eo, ee, lat, o, e;
        bit known;
        modelExec(act, a, idx, din, eo, ee, known);
        doReq(act, a, idx, din, lat, o, e);
        check({tag, "_latency"}, lat, 3);
        check({tag, "_error"}, e, ee);
        if (known) check({tag, "_out"}, o, eo);
    endtask

    initial begin
        int lat, o, e, eo, ee, eo2, ee2, acks, o2, e2;
        bit known, known2;
        logic prevAck;

        for (int i = 0; i < 16; i++) begin
            mMem[i]   = 0;
            mValid[i] = 1'b0;
        end
        modelReset();
        bus.heap_clock = 1'b0;
        drive(0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1;
        check("reset_out", bus.heap_out, 0);
        check("reset_error", bus.heap_error, 0);
        check("reset_ack", bus.heap_ack, 0);
        check("reset_busy", bus.heap_busy, 0);
        reset = 1'b0;

        addVec(ALLOC, 0, 0, 0, 0, 0);   addVec(ALLOC, 0, 0, 0, 1, 0);
        addVec(PUSH, 0, 0, 5, 0, 0);    addVec(PUSH, 0, 0, 7, 0, 0);
        addVec(LENGTH, 0, 0, 0, 2, 0);  addVec(POP, 0, 0, 0, 7, 0);
        addVec(LENGTH, 0, 0, 0, 1, 0);  addVec(RESIZE, 0, 0, 0, 0, 0);
        addVec(PUSH, 0, 0, 10, 0, 0);   addVec(PUSH, 0, 0, 11, 0, 0);
        addVec(PUSH, 0, 0, 12, 0, 0);   addVec(PUSH, 0, 0, 13, 0, 0);
        addVec(PUSH, 0, 0, 14, 0, 4);   addVec(LENGTH, 0, 0, 0, 4, 0);
        addVec(POP, 1, 0, 0, 0, 5);     addVec(READ, 3, 2, 0, 0, 2);
        addVec(READ, 0, 2, 0, 12, 0);   addVec(WRITE, 1, 3, 99, 0, 0);
        addVec(LENGTH, 1, 0, 0, 4, 0);  addVec(RESIZE, 0, 0, 5, 0, 6);
        addVec(LENGTH, 0, 0, 0, 4, 0);  addVec(9, 0, 0, 0, 0, 7);
        addVec(FREE, 1, 0, 0, 0, 0);    addVec(LENGTH, 1, 0, 0, 0, 2);
        addVec(ALLOC, 3, 0, 0, 1, 0);   addVec(WRITE, 1, 0, 42, 0, 0);
        if (BOUNDS) addVec(READ, 1, 3, 0, 0, 3);
        else        addVec(READ, 1, 3, 0, 99, 0);
        addVec(ALLOC, 0, 0, 0, 2, 0);   addVec(ALLOC, 0, 0, 0, 3, 0);
        addVec(ALLOC, 0, 0, 0, 0, 1);   addVec(POP, 0, 0, 0, 13, 0);
        if (BOUNDS) addVec(READ, 0, 3, 0, 0, 3);
        else        addVec(READ, 0, 3, 0, 13, 0);

        foreach (vecs[i]) begin
            modelExec(vecs[i].act, vecs[i].arr, vecs[i].idx, vecs[i].din, eo, ee, known);
            doReq(vecs[i].act, vecs[i].arr, vecs[i].idx, vecs[i].din, lat, o, e);
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_error", i), e, vecs[i].expErr);
            check($sformatf("vec%0d_out", i), o, vecs[i].expOut);
        end

        // Two toggles while busy cancel out; operand changes while busy are ignored.
        modelExec(LENGTH, 0, 0, 0, eo, ee, known);
        @(posedge clock); #1;
        drive(LENGTH, 0, 0, 0);
        bus.heap_clock = ~bus.heap_clock;
        prevAck = bus.heap_ack;
        @(posedge clock); #1;
        drive(POP, 0, 0, 0);
        bus.heap_clock = ~bus.heap_clock;
        @(posedge clock); #1;
        bus.heap_clock = ~bus.heap_clock;
        @(posedge clock); #1;
        check("even_ack_toggled", bus.heap_ack != prevAck, 1);
        check("even_out", bus.heap_out, eo);
        prevAck = bus.heap_ack;
        acks = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clock); #1;
            if (bus.heap_ack != prevAck) begin
                acks++;
                prevAck = bus.heap_ack;
            end
        end
        check("even_extra_acks", acks, 0);
        runChecked("even_after", LENGTH, 0, 0, 0);

        // Three toggles while busy leave exactly one request pending.
        modelExec(LENGTH, 0, 0, 0, eo, ee, known);
        modelExec(LENGTH, 2, 0, 0, eo2, ee2, known2);
        @(posedge clock); #1;
        drive(LENGTH, 0, 0, 0);
        bus.heap_clock = ~bus.heap_clock;
        prevAck = bus.heap_ack;
        @(posedge clock); #1;
        drive(LENGTH, 2, 0, 0);
        bus.heap_clock = ~bus.heap_clock;
        #2 bus.heap_clock = ~bus.heap_clock;
        @(posedge clock); #1;
        bus.heap_clock = ~bus.heap_clock;
        acks = 0;
        o = -1; e = -1; o2 = -1; e2 = -1;
        for (int n = 0; n < 14; n++) begin
            @(posedge clock); #1;
            if (bus.heap_ack != prevAck) begin
                acks++;
                prevAck = bus.heap_ack;
                if (acks == 1) begin o = int'(bus.heap_out); e = int'(bus.heap_error); end
                if (acks == 2) begin o2 = int'(bus.heap_out); e2 = int'(bus.heap_error); end
            end
        end
        check("odd_ack_count", acks, 2);
        check("odd_first_out", o, eo);
        check("odd_second_out", o2, eo2);
        check("odd_second_error", e2, ee2);

        // Reset during EXEC of a WRITE abandons it without an ack.
        @(posedge clock); #1;
        drive(WRITE, 0, 1, 77);
        bus.heap_clock = ~bus.heap_clock;
        @(posedge clock); #1;
        check("rst_busy_exec", bus.heap_busy, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        modelReset();
        check("rst_ack_zero", bus.heap_ack, 0);
        prevAck = bus.heap_ack;
        acks = 0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clock); #1;
            if (bus.heap_ack != prevAck) begin
                acks++;
                prevAck = bus.heap_ack;
            end
        end
        check("rst_no_ack", acks, 0);
        check("rst_busy", bus.heap_busy, 0);
        check("rst_out", bus.heap_out, 0);
        check("rst_error", bus.heap_error, 0);
        runChecked("rst_alloc", ALLOC, 0, 0, 0);
        runChecked("rst_length", LENGTH, 0, 0, 0);
        runChecked("rst_read", READ, 0, 1, 0);

        for (int i = 0; i < 300; i++) begin
            int act, a, idx, din;
            act = $urandom_range(0, 10);
            if ($urandom_range(0, 5) == 0) act = ALLOC;
            a   = $urandom_range(0, 3);
            idx = $urandom_range(0, 3);
            din = (act == RESIZE) ? $urandom_range(0, 6) : $urandom_range(0, 4095);
            runChecked($sformatf("rand%0d_act%0d", i, act), act, a, idx, din);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/heap_responder.md
HEAP_RESPONDER -- requirements
Module: heap_responder

Interface
REQ-001 Parameter WIDTH, default 12, SHALL set the bit width of each element.
REQ-002 Parameter ARRAYS, default 4, SHALL set the number of arrays (power of 2).
REQ-003 Parameter SIZE, default 4, SHALL set the maximum elements per array (power of 2).
REQ-004 Ports SHALL be:
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- heap_clock  in  1  request toggle from the initiator
- heap_action  in  8  operation code
- heap_array  in  log2(ARRAYS)  array number
- heap_index  in  log2(SIZE)  element index
- heap_in  in  WIDTH  input data
- heap_out  out  WIDTH  result data
- heap_error  out  32  error code, 0 = none
- heap_ack  out  1  toggles once per completed request
- heap_busy  out  1  high while a request is executing

Function
REQ-005 A request SHALL be pending when heap_clock differs from the internal served_phase register.
REQ-006 The state machine SHALL have states IDLE, EXEC and DONE.
REQ-007 State transitions SHALL be as follows:
- IDLE to EXEC when a request is pending: capture all operands and set served_phase equal to heap_clock.
- EXEC to DONE unconditionally: perform the action and register heap_out and heap_error.
- DONE to IDLE: toggle heap_ack.
REQ-008 heap_busy SHALL be high exactly in EXEC and DONE.
REQ-009 Request latency SHALL be 3 cycles from the edge sampling the toggle to heap_ack changing; heap_out and heap_error SHALL be stable before the ack toggle.
REQ-010 Input changes while busy SHALL be ignored. An odd number of heap_clock toggles while busy SHALL leave one request pending; an even number SHALL leave none.
REQ-011 Per array, the block SHALL track an alloc flag and a length 0..SIZE.
REQ-012 Actions (codes defined in the package):
- NOP=0: no effect, error 0.
- ALLOC=1: claim the lowest free array; out = array number, length = 0.
- FREE=2: clear the alloc flag.
- READ=3: out = mem[index].
- WRITE=4: mem[index] = heap_in; length = max(length, index+1).
- LENGTH=5: out = length.
- PUSH=6: mem[length] = heap_in; length+1.
- POP=7: length-1; out = popped element.
- RESIZE=8: length = heap_in.
REQ-013 Error codes SHALL be:
- 1 = ALLOC with no free array.
- 2 = any action other than NOP/ALLOC on an unallocated array.
- 3 = READ with index >= length.
- 4 = PUSH when length == SIZE.
- 5 = POP when length == 0.
- 6 = RESIZE with heap_in > SIZE.
- 7 = unknown action.
REQ-014 On any error, array state SHALL be unchanged and heap_out SHALL be 0.
REQ-015 Without the macro in REQ-020, index arithmetic SHALL wrap modulo SIZE and error 3 SHALL never be raised.

Reset
REQ-016 While reset is high, the FSM SHALL enter IDLE.
REQ-017 Reset SHALL set these outputs to 0: heap_out, heap_error, heap_ack, heap_busy.
REQ-018 Reset SHALL clear all alloc flags and lengths, and SHALL load served_phase from heap_clock so that no spurious request occurs.
REQ-019 Reset mid-request SHALL abandon the request with no ack; element storage SHALL not be cleared.

Configuration
REQ-020 With HEAP_BOUNDS_CHECK_EN defined, the block SHALL raise error 3 for READ with index >= length, and for WRITE with index >= SIZE; without it, REQ-015 SHALL apply.

Structure
REQ-021 Package heap_pkg SHALL hold the action code enum, error code constants and the FSM state typedef.
REQ-022 Element storage SHALL be a sub-module heap_array_ram: single-port, synchronous write, combinational read, ARRAYS*SIZE words of WIDTH bits.

Verification
REQ-023 Reset, then ALLOC twice: acks toggle; heap_out is 0 then 1; heap_error is 0.
REQ-024 On array 0: PUSH 5, PUSH 7, LENGTH gives out=2; POP gives out=7; LENGTH gives out=1.
REQ-025 Fill array 0 with 4 PUSHes, then PUSH again: error 4, length remains 4. POP on an empty array: error 5.
REQ-026 READ index 2 on array 3 without ALLOC: error 2. With HEAP_BOUNDS_CHECK_EN, READ index 3 on an array of length 1: error 3.
REQ-027 Toggle heap_clock twice during EXEC: no extra ack. Toggle three times: exactly one further request is served.
REQ-028 Assert reset during EXEC of a WRITE: no ack, lengths are 0 afterwards, and the next request completes with 3-cycle latency.
